// File: rtl/scanchain_pkg.sv
// Shared types and width helpers for the scan-chain master.
package scanchain_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StShift,
      StLatch,
      StResp
   } state_e;

   // Counter width for a modulus of n, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scanchain_driver_scan_clk_gen.sv
// Scan-clock divider: CLK_DIV clocks low, then CLK_DIV clocks high, restartable per state.
module scan_clk_gen
   import scanchain_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic scan_clk,
   output logic fall_stb,
   output logic sample_stb,
   output logic half_done,
   output logic cycle_done
);

   localparam int unsigned DivW = cnt_width(CLK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic [DivW-1:0] div_q;
   logic            phase_q;

   always_ff @(posedge clk) begin
      if (rst || restart || !run) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else if (div_q == DivLast) begin
         div_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         div_q <= div_q + DivW'(1);
      end
   end

   // The last high clock ends the cycle; its edge also starts the next low phase.
   assign scan_clk   = phase_q;
   assign sample_stb = run && phase_q && (div_q == DivLast);
   assign fall_stb   = sample_stb;
   assign cycle_done = sample_stb;
   assign half_done  = run && !phase_q && (div_q == DivLast);

endmodule

// File: rtl/scanchain_driver.sv
// Scan-chain master: shifts a parallel word through the chain and returns the word shifted out.
module scanchain_driver
   import scanchain_pkg::*;
#(
   parameter int unsigned SCAN_LENGTH = 8,
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned LATCH_EN    = 1
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic [SCAN_LENGTH-1:0] tx_data,
   input  logic                   tx_capture,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [SCAN_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   busy,
   output logic                   scan_clk_out,
   output logic                   scan_data_out,
   output logic                   scan_select_out,
   output logic                   latch_enable_out,
   input  logic                   scan_data_in
);

   localparam int unsigned BitW = $clog2(SCAN_LENGTH + 1);
   localparam logic [BitW-1:0] BitLast = BitW'(SCAN_LENGTH - 1);
   localparam logic [BitW-1:0] BitMax  = BitW'(SCAN_LENGTH);

   state_e                 state_q, state_d;
   logic [SCAN_LENGTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
   logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                   data_q, data_d, sel_q, sel_d, latch_q, latch_d;
   logic                   rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, busy_q, busy_d;
   logic                   run, restart, fall_stb, sample_stb, half_done, cycle_done;
   logic                   last_bit;

   assign run      = state_q inside {StCapture, StShift, StLatch};
   assign restart  = (state_d != state_q);
   assign last_bit = (bit_cnt_q == BitLast);

   scan_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_gen (
      .clk       (clk_in),
      .rst       (reset_in),
      .run       (run),
      .restart   (restart),
      .scan_clk  (scan_clk_out),
      .fall_stb  (fall_stb),
      .sample_stb(sample_stb),
      .half_done (half_done),
      .cycle_done(cycle_done)
   );

   always_comb begin
      state_d   = state_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      sel_d     = sel_q;
      latch_d   = latch_q;
      unique case (state_q)
         StIdle: begin
            if (tx_valid && tx_ready_q) begin
               bit_cnt_d = '0;
               if (tx_capture) begin
                  state_d = StCapture;
                  tx_sr_d = tx_data;
                  sel_d   = 1'b1;
                  data_d  = 1'b0;
               end else begin
                  // Scan clock is already low, so the first bit goes out immediately.
                  state_d = StShift;
                  tx_sr_d = {tx_data[SCAN_LENGTH-2:0], 1'b0};
                  data_d  = tx_data[SCAN_LENGTH-1];
               end
            end
         end
         StCapture: begin
            if (fall_stb) begin
               sel_d   = 1'b0;
               data_d  = tx_sr_q[SCAN_LENGTH-1];
               tx_sr_d = {tx_sr_q[SCAN_LENGTH-2:0], 1'b0};
            end
            if (cycle_done) state_d = StShift;
         end
         StShift: begin
            if (sample_stb) rx_sr_d = {rx_sr_q[SCAN_LENGTH-2:0], scan_data_in};
            if (cycle_done && (bit_cnt_q != BitMax)) bit_cnt_d = bit_cnt_q + BitW'(1);
            if (fall_stb) begin
               data_d  = last_bit ? 1'b0 : tx_sr_q[SCAN_LENGTH-1];
               tx_sr_d = {tx_sr_q[SCAN_LENGTH-2:0], 1'b0};
            end
            if (cycle_done && last_bit) begin
               state_d = (LATCH_EN != 0) ? StLatch : StResp;
               latch_d = (LATCH_EN != 0);
            end
         end
         StLatch: begin
            if (half_done) begin
               state_d = StResp;
               latch_d = 1'b0;
            end
         end
         StResp: begin
            if (!rx_valid_q) rx_data_d = rx_sr_q;
            if (rx_valid_q && rx_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign rx_valid_d = (state_q == StResp) && !(rx_valid_q && rx_ready);
   assign tx_ready_d = (state_d == StIdle);
   assign busy_d     = (state_d != StIdle);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q    <= StIdle;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         data_q     <= 1'b0;
         sel_q      <= 1'b0;
         latch_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         latch_q    <= latch_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_ready         = tx_ready_q;
   assign busy             = busy_q;
   assign rx_valid         = rx_valid_q;
   assign rx_data          = rx_data_q;
   assign scan_data_out    = data_q;
   assign scan_select_out  = sel_q;
   assign latch_enable_out = latch_q;

endmodule

// File: tb/tb_scanchain_driver.sv
// Bench for scanchain_driver: three configurations, each driving a behavioural posedge chain.
module tb_scanchain_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_in;
   logic [31:0] tx_data;
   logic        tx_capture;
   logic [2:0]  tx_valid;
   logic        rx_ready;
   int          checks = 0;
   int          errors = 0;

   // Configuration 0: 8 bits, divide by 2, latch enabled, with parallel capture.
   logic [7:0] rx_data0;
   logic       tx_ready0, rx_valid0, busy0, sc0, sd0, ss0, le0;
   logic [7:0] ch0  = '0;
   logic [7:0] mdo0 = '0;
   logic       end0 = 1'b0;

   scanchain_driver #(.SCAN_LENGTH(8), .CLK_DIV(2), .LATCH_EN(1)) u_dut0 (
      .clk_in(clk), .reset_in(reset_in), .tx_data(tx_data[7:0]), .tx_capture(tx_capture),
      .tx_valid(tx_valid[0]), .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .rx_ready(rx_ready), .busy(busy0), .scan_clk_out(sc0), .scan_data_out(sd0),
      .scan_select_out(ss0), .latch_enable_out(le0), .scan_data_in(end0)
   );
   always @(posedge sc0) ch0 <= ss0 ? mdo0 : {ch0[6:0], sd0};
   always @(negedge sc0) end0 <= ch0[7];

   // Configuration 1: 2 bits, divide by 1, no latch phase.
   logic [1:0] rx_data1;
   logic       tx_ready1, rx_valid1, busy1, sc1, sd1, ss1, le1;
   logic [1:0] ch1  = '0;
   logic       end1 = 1'b0;

   scanchain_driver #(.SCAN_LENGTH(2), .CLK_DIV(1), .LATCH_EN(0)) u_dut1 (
      .clk_in(clk), .reset_in(reset_in), .tx_data(tx_data[1:0]), .tx_capture(tx_capture),
      .tx_valid(tx_valid[1]), .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .rx_ready(rx_ready), .busy(busy1), .scan_clk_out(sc1), .scan_data_out(sd1),
      .scan_select_out(ss1), .latch_enable_out(le1), .scan_data_in(end1)
   );
   always @(posedge sc1) ch1 <= ss1 ? 2'b00 : {ch1[0], sd1};
   always @(negedge sc1) end1 <= ch1[1];

   // Configuration 2: 32 bits, divide by 3, latch enabled.
   logic [31:0] rx_data2;
   logic        tx_ready2, rx_valid2, busy2, sc2, sd2, ss2, le2;
   logic [31:0] ch2  = '0;
   logic        end2 = 1'b0;

   scanchain_driver #(.SCAN_LENGTH(32), .CLK_DIV(3), .LATCH_EN(1)) u_dut2 (
      .clk_in(clk), .reset_in(reset_in), .tx_data(tx_data), .tx_capture(tx_capture),
      .tx_valid(tx_valid[2]), .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2),
      .rx_ready(rx_ready), .busy(busy2), .scan_clk_out(sc2), .scan_data_out(sd2),
      .scan_select_out(ss2), .latch_enable_out(le2), .scan_data_in(end2)
   );
   always @(posedge sc2) ch2 <= ss2 ? 32'h0 : {ch2[30:0], sd2};
   always @(negedge sc2) end2 <= ch2[31];

   // Monitor view of the configuration currently under test.
   int          sel = 0;
   logic        m_ready, m_valid, m_busy, m_clk, m_data, m_sel, m_latch;
   logic [31:0] m_rx, m_chain;

   always_comb begin
      case (sel)
         1: begin
            m_ready = tx_ready1; m_valid = rx_valid1; m_busy = busy1; m_clk = sc1;
            m_data = sd1; m_sel = ss1; m_latch = le1; m_rx = {30'h0, rx_data1};
            m_chain = {30'h0, ch1};
         end
         2: begin
            m_ready = tx_ready2; m_valid = rx_valid2; m_busy = busy2; m_clk = sc2;
            m_data = sd2; m_sel = ss2; m_latch = le2; m_rx = rx_data2; m_chain = ch2;
         end
         default: begin
            m_ready = tx_ready0; m_valid = rx_valid0; m_busy = busy0; m_clk = sc0;
            m_data = sd0; m_sel = ss0; m_latch = le0; m_rx = {24'h0, rx_data0};
            m_chain = {24'h0, ch0};
         end
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called and returns on a negedge. With stall > 0 the response is held off for that many
   // clocks while the next request (next_d) is already presented.
   task automatic do_txn(input int s, input logic [31:0] d, input logic c,
                         input logic [31:0] exp_rx, input logic [31:0] exp_chain,
                         input int exp_lat, input int exp_edges, input int exp_sels,
                         input int exp_latch, input int stall, input logic [31:0] next_d);
      int   n, lat, edges, sels, lclk, bad;
      logic prev;
      sel = s;
      tx_data = d;
      tx_capture = c;
      tx_valid[s] = 1'b1;
      rx_ready = 1'b0;
      n = 0;
      while (!m_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx_ready_wait", m_ready, 1);
      prev = m_clk;
      @(negedge clk);
      tx_valid[s] = 1'b0;
      lat = 0; edges = 0; sels = 0; lclk = 0;
      while (!m_valid && lat < 400) begin
         if (m_clk && !prev) begin
            edges++;
            if (m_sel) sels++;
         end
         if (m_latch) lclk++;
         prev = m_clk;
         @(negedge clk);
         lat++;
      end
      check_eq("rx_latency", lat, exp_lat);
      check_eq("scan_edges", edges, exp_edges);
      check_eq("select_cycles", sels, exp_sels);
      check_eq("latch_clocks", lclk, exp_latch);
      check_eq("rx_data", m_rx, exp_rx);
      check_eq("chain", m_chain, exp_chain);
      if (stall > 0) begin
         bad = 0;
         tx_data = next_d;
         tx_capture = 1'b0;
         tx_valid[s] = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!m_valid || m_ready || !m_busy || (m_rx !== exp_rx)) bad++;
         end
         check_eq("stall_hold", bad, 0);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check_eq("rx_valid_drop", m_valid, 0);
      check_eq("tx_ready_back", m_ready, 1);
   endtask

   initial begin
      int   n, edges, seen;
      logic prev;
      reset_in = 1'b1;
      tx_valid = '0;
      tx_data = '0;
      tx_capture = 1'b0;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx_ready", m_ready, 1);
      check_eq("rst_busy", m_busy, 0);
      check_eq("rst_rx_valid", m_valid, 0);
      check_eq("rst_scan_clk", m_clk, 0);
      check_eq("rst_latch", m_latch, 0);
      reset_in = 1'b0;
      @(negedge clk);

      // Plain write, capture-then-read, stalled response with a queued request, follow-up.
      do_txn(0, 32'hA5, 1'b0, 32'h00, 32'hA5, 35, 8, 0, 2, 0, 32'h0);
      mdo0 = 8'h3C;
      do_txn(0, 32'h00, 1'b1, 32'h3C, 32'h00, 39, 9, 1, 2, 0, 32'h0);
      do_txn(0, 32'h5A, 1'b0, 32'h00, 32'h5A, 35, 8, 0, 2, 10, 32'hC3);
      do_txn(0, 32'hC3, 1'b0, 32'h5A, 32'hC3, 35, 8, 0, 2, 0, 32'h0);

      // Abort in the middle of the shift.
      sel = 0;
      tx_data = 32'hFF;
      tx_capture = 1'b0;
      tx_valid[0] = 1'b1;
      n = 0;
      edges = 0;
      prev = m_clk;
      while (edges < 4 && n < 200) begin
         @(negedge clk);
         tx_valid[0] = 1'b0;
         if (m_clk && !prev) edges++;
         prev = m_clk;
         n++;
      end
      check_eq("abort_reach", edges, 4);
      reset_in = 1'b1;
      @(negedge clk);
      reset_in = 1'b0;
      check_eq("abort_scan_clk", m_clk, 0);
      check_eq("abort_data", m_data, 0);
      check_eq("abort_select", m_sel, 0);
      check_eq("abort_latch", m_latch, 0);
      check_eq("abort_rx_valid", m_valid, 0);
      check_eq("abort_busy", m_busy, 0);
      check_eq("abort_tx_ready", m_ready, 1);
      check_eq("abort_rx_data", m_rx, 0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (m_valid) seen++;
      end
      check_eq("abort_no_rx", seen, 0);

      // Minimal configuration.
      do_txn(1, 32'h2, 1'b0, 32'h0, 32'h2, 5, 2, 0, 0, 0, 32'h0);
      do_txn(1, 32'h1, 1'b0, 32'h2, 32'h1, 5, 2, 0, 0, 0, 32'h0);

      // Wide configuration, walking one round trip.
      do_txn(2, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h0000_0001, 196, 32, 0, 3, 0, 32'h0);
      do_txn(2, 32'h0000_0020, 1'b0, 32'h0000_0001, 32'h0000_0020, 196, 32, 0, 3, 0, 32'h0);
      do_txn(2, 32'h8000_0000, 1'b0, 32'h0000_0020, 32'h8000_0000, 196, 32, 0, 3, 0, 32'h0);
      do_txn(2, 32'h0000_0000, 1'b0, 32'h8000_0000, 32'h0000_0000, 196, 32, 0, 3, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
